// File: rtl/frame_aligner_gen_if.sv
// Rx word stream into the frame aligner and the aligner's status back out.
// master drives rx words and reads status; slave is the aligner itself.
interface frame_aligner_gen_if #(
  parameter int DATA_W = 8,
  parameter int POS_W  = 4
);
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [POS_W-1:0]  fr_byte_position;
  logic              frame_detect;
  logic              hdr_type;
  logic [1:0]        sync_state;
  logic              frame_err;

  modport master (
    output rx_valid, rx_data,
    input  fr_byte_position, frame_detect,
    input  hdr_type, sync_state, frame_err
  );

  modport slave (
    input  rx_valid, rx_data,
    output fr_byte_position, frame_detect,
    output hdr_type, sync_state, frame_err
  );
endinterface

// File: rtl/frame_aligner_gen.sv
// Frame aligner: hunts for header A/B, tracks word position in the frame,
// locks after SYNC_CNT good headers and unlocks after LOSS_CNT bad ones.
module frame_aligner_gen #(
  parameter int DATA_W    = 8,
  parameter int HDR_WORDS = 2,
  parameter logic [HDR_WORDS*DATA_W-1:0] HDR_A = 16'hAFAA,
  parameter logic [HDR_WORDS*DATA_W-1:0] HDR_B = 16'hBA55,
  parameter int FRAME_LEN = 12,
  parameter int SYNC_CNT  = 3,
  parameter int LOSS_CNT  = 4,
  parameter int POS_W     = $clog2(FRAME_LEN)
) (
  input  logic clk,
  input  logic reset,
  frame_aligner_gen_if.slave bus
);
  localparam int HDR_W = HDR_WORDS * DATA_W;
  localparam int GW    = $clog2(SYNC_CNT + 1);
  localparam int BW    = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t            state;
  logic [HDR_W-1:0]  window;
  logic [GW-1:0]     good_cnt;
  logic [BW-1:0]     bad_cnt;
  logic [POS_W-1:0]  pos;
  logic              det_q;
  logic              hdr_q;
  logic              err_q;

  logic [HDR_W+DATA_W-1:0] cat;
  logic [HDR_W-1:0]        win_nxt;
  logic [POS_W-1:0]        pos_inc;
  logic                    match_a;
  logic                    match_b;
  logic                    match;
  logic                    chk_pt;

  assign cat     = {window, bus.rx_data};
  assign win_nxt = cat[HDR_W-1:0];
  assign match_a = (win_nxt == HDR_A);
  assign match_b = (win_nxt == HDR_B);
  assign match   = match_a | match_b;
  assign pos_inc = (pos == POS_W'(FRAME_LEN - 1))
                 ? '0 : pos + 1'b1;
  // Once aligned, only the last header word of each frame is judged.
  assign chk_pt  = (pos_inc == POS_W'(HDR_WORDS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEARCH;
      window   <= '0;
      good_cnt <= '0;
      bad_cnt  <= '0;
      pos      <= '0;
      det_q    <= 1'b0;
      hdr_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (bus.rx_valid) begin
        window <= win_nxt;
        unique case (state)
          SEARCH: begin
            if (match) begin
              good_cnt <= GW'(1);
              hdr_q    <= ~match_a;
              pos      <= POS_W'(HDR_WORDS - 1);
              if (SYNC_CNT == 1) begin
                state <= LOCKED;
                det_q <= 1'b1;
              end else begin
                state <= VERIFY;
              end
            end else begin
              pos <= '0;
            end
          end
          VERIFY: begin
            pos <= pos_inc;
            if (chk_pt) begin
              if (match) begin
                good_cnt <= good_cnt + 1'b1;
                hdr_q    <= ~match_a;
                if (good_cnt == GW'(SYNC_CNT - 1)) begin
                  state <= LOCKED;
                  det_q <= 1'b1;
                end
              end else begin
                state    <= SEARCH;
                good_cnt <= '0;
                pos      <= '0;
              end
            end
          end
          LOCKED: begin
            pos <= pos_inc;
            if (chk_pt) begin
              if (match) begin
                bad_cnt <= '0;
                hdr_q   <= ~match_a;
              end else begin
                err_q <= 1'b1;
                if (bad_cnt == BW'(LOSS_CNT - 1)) begin
                  state    <= SEARCH;
                  det_q    <= 1'b0;
                  good_cnt <= '0;
                  bad_cnt  <= '0;
                  pos      <= '0;
                end else begin
                  bad_cnt <= bad_cnt + 1'b1;
                end
              end
            end
          end
          default: state <= SEARCH;
        endcase
      end
    end
  end

  assign bus.fr_byte_position = pos;
  assign bus.frame_detect     = det_q;
  assign bus.hdr_type         = hdr_q;
  assign bus.sync_state       = state;
  assign bus.frame_err        = err_q;
endmodule

// File: tb/tb_frame_aligner_gen.sv
// Directed bench for frame_aligner_gen with default parameters:
// frame = 2 header words + 10 payload words (01..0A).
module tb_frame_aligner_gen;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_fail = 0;

  frame_aligner_gen_if #(.DATA_W(8), .POS_W(4)) bus ();

  frame_aligner_gen dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic payload();
    for (int i = 1; i <= 10; i++) send(8'(i));
  endtask

  task automatic send_frame(input logic [7:0] h0, input logic [7:0] h1);
    send(h0);
    send(h1);
    payload();
  endtask

  task automatic do_reset();
    bus.rx_valid = 1'b0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    idle(1);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (4) begin
      bus.rx_valid = 1'($urandom);
      bus.rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    n_chk++;
    if ({bus.fr_byte_position, bus.frame_detect, bus.hdr_type,
         bus.sync_state, bus.frame_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outs: pos=%0d det=%0d hdr=%0d st=%0d err=%0d want all 0",
               bus.fr_byte_position, bus.frame_detect, bus.hdr_type,
               bus.sync_state, bus.frame_err);
    end
    bus.rx_valid = 1'b0;
    reset = 1'b1;
    idle(1);
    n_chk++;
    if (bus.sync_state !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release: sync_state=%0d want 0", bus.sync_state);
    end
  endtask

  task automatic test_lock();
    send(8'hAF);
    n_chk++;
    if (bus.sync_state !== 2'd0 || bus.fr_byte_position !== 4'd0) begin
      n_fail++;
      $display("FAIL lock_first_af: st=%0d pos=%0d want 0 0",
               bus.sync_state, bus.fr_byte_position);
    end
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.fr_byte_position !== 4'd1) begin
      n_fail++;
      $display("FAIL lock_verify: st=%0d pos=%0d want 1 1",
               bus.sync_state, bus.fr_byte_position);
    end
    for (int i = 1; i <= 10; i++) begin
      send(8'(i));
      n_chk++;
      if (bus.fr_byte_position !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL lock_pos1: pos=%0d want %0d", bus.fr_byte_position, i + 1);
      end
    end
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.frame_detect !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_second: st=%0d det=%0d want 1 0",
               bus.sync_state, bus.frame_detect);
    end
    payload();
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd2 || bus.frame_detect !== 1'b1 ||
        bus.hdr_type !== 1'b0 || bus.fr_byte_position !== 4'd1) begin
      n_fail++;
      $display("FAIL lock_third: st=%0d det=%0d hdr=%0d pos=%0d want 2 1 0 1",
               bus.sync_state, bus.frame_detect, bus.hdr_type, bus.fr_byte_position);
    end
    for (int i = 1; i <= 10; i++) begin
      send(8'(i));
      n_chk++;
      if (bus.fr_byte_position !== 4'(i + 1)) begin
        n_fail++;
        $display("FAIL lock_pos3: pos=%0d want %0d", bus.fr_byte_position, i + 1);
      end
    end
  endtask

  task automatic test_loss();
    for (int k = 0; k < 4; k++) begin
      send(8'h00);
      n_chk++;
      if (bus.frame_err !== 1'b0 || bus.fr_byte_position !== 4'd0) begin
        n_fail++;
        $display("FAIL loss_w0_%0d: err=%0d pos=%0d want 0 0",
                 k, bus.frame_err, bus.fr_byte_position);
      end
      send(8'h00);
      n_chk++;
      if (bus.frame_err !== 1'b1) begin
        n_fail++;
        $display("FAIL loss_err_%0d: err=%0d want 1", k, bus.frame_err);
      end
      if (k < 3) begin
        n_chk++;
        if (bus.sync_state !== 2'd2 || bus.frame_detect !== 1'b1 ||
            bus.fr_byte_position !== 4'd1) begin
          n_fail++;
          $display("FAIL loss_hold_%0d: st=%0d det=%0d pos=%0d want 2 1 1",
                   k, bus.sync_state, bus.frame_detect, bus.fr_byte_position);
        end
      end else begin
        n_chk++;
        if (bus.sync_state !== 2'd0 || bus.frame_detect !== 1'b0 ||
            bus.fr_byte_position !== 4'd0) begin
          n_fail++;
          $display("FAIL loss_drop: st=%0d det=%0d pos=%0d want 0 0 0",
                   bus.sync_state, bus.frame_detect, bus.fr_byte_position);
        end
      end
      send(8'h01);
      n_chk++;
      if (bus.frame_err !== 1'b0) begin
        n_fail++;
        $display("FAIL loss_pulse_%0d: err=%0d want 0", k, bus.frame_err);
      end
      for (int i = 2; i <= 10; i++) send(8'(i));
    end
    n_chk++;
    if (bus.sync_state !== 2'd0 || bus.fr_byte_position !== 4'd0) begin
      n_fail++;
      $display("FAIL loss_search: st=%0d pos=%0d want 0 0",
               bus.sync_state, bus.fr_byte_position);
    end
  endtask

  task automatic test_hdr_b();
    repeat (3) send_frame(8'hAF, 8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd2) begin
      n_fail++;
      $display("FAIL hdrb_lock: st=%0d want 2", bus.sync_state);
    end
    repeat (3) send_frame(8'h00, 8'h00);
    send(8'hBA);
    send(8'h55);
    n_chk++;
    if (bus.sync_state !== 2'd2 || bus.hdr_type !== 1'b1 || bus.frame_err !== 1'b0) begin
      n_fail++;
      $display("FAIL hdrb_match: st=%0d hdr=%0d err=%0d want 2 1 0",
               bus.sync_state, bus.hdr_type, bus.frame_err);
    end
    payload();
    repeat (3) send_frame(8'h00, 8'h00);
    n_chk++;
    if (bus.sync_state !== 2'd2 || bus.frame_detect !== 1'b1 || bus.hdr_type !== 1'b1) begin
      n_fail++;
      $display("FAIL hdrb_cleared: st=%0d det=%0d hdr=%0d want 2 1 1",
               bus.sync_state, bus.frame_detect, bus.hdr_type);
    end
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.hdr_type !== 1'b0) begin
      n_fail++;
      $display("FAIL hdrb_back_a: hdr=%0d want 0", bus.hdr_type);
    end
    payload();
  endtask

  task automatic test_stall();
    do_reset();
    send(8'hAF);
    send(8'hAA);
    for (int i = 1; i <= 3; i++) send(8'(i));
    idle(5);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.fr_byte_position !== 4'd4) begin
      n_fail++;
      $display("FAIL stall_hold: st=%0d pos=%0d want 1 4",
               bus.sync_state, bus.fr_byte_position);
    end
    for (int i = 4; i <= 10; i++) send(8'(i));
    n_chk++;
    if (bus.fr_byte_position !== 4'd11) begin
      n_fail++;
      $display("FAIL stall_pos: pos=%0d want 11", bus.fr_byte_position);
    end
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.frame_detect !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_second: st=%0d det=%0d want 1 0",
               bus.sync_state, bus.frame_detect);
    end
    payload();
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd2 || bus.frame_detect !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_lock: st=%0d det=%0d want 2 1",
               bus.sync_state, bus.frame_detect);
    end
  endtask

  task automatic test_false_hdr();
    do_reset();
    send(8'h05);
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.fr_byte_position !== 4'd1) begin
      n_fail++;
      $display("FAIL false_verify: st=%0d pos=%0d want 1 1",
               bus.sync_state, bus.fr_byte_position);
    end
    payload();
    send(8'h12);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.fr_byte_position !== 4'd0) begin
      n_fail++;
      $display("FAIL false_wrap: st=%0d pos=%0d want 1 0",
               bus.sync_state, bus.fr_byte_position);
    end
    send(8'h34);
    n_chk++;
    if (bus.sync_state !== 2'd0 || bus.fr_byte_position !== 4'd0) begin
      n_fail++;
      $display("FAIL false_search: st=%0d pos=%0d want 0 0",
               bus.sync_state, bus.fr_byte_position);
    end
    send(8'hAF);
    send(8'hAA);
    send(8'h01);
    send(8'h02);
    send(8'h03);
    send(8'hAF);
    send(8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd1 || bus.fr_byte_position !== 4'd6) begin
      n_fail++;
      $display("FAIL false_midframe: st=%0d pos=%0d want 1 6",
               bus.sync_state, bus.fr_byte_position);
    end
    for (int i = 6; i <= 10; i++) send(8'(i));
    repeat (2) send_frame(8'hAF, 8'hAA);
    n_chk++;
    if (bus.sync_state !== 2'd2) begin
      n_fail++;
      $display("FAIL false_relock: st=%0d want 2", bus.sync_state);
    end
    #2 reset = 1'b0;
    #1;
    n_chk++;
    if ({bus.fr_byte_position, bus.frame_detect, bus.hdr_type,
         bus.sync_state, bus.frame_err} !== 9'd0) begin
      n_fail++;
      $display("FAIL async_reset: pos=%0d det=%0d st=%0d want all 0",
               bus.fr_byte_position, bus.frame_detect, bus.sync_state);
    end
    #2 reset = 1'b1;
    idle(1);
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    test_reset();
    test_lock();
    test_loss();
    test_hdr_b();
    test_stall();
    test_false_hdr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
